// File: rtl/vga_timing_pkg.sv
// Default 640x480@60 timing constants and the shared coordinate type.
package vga_timing_pkg;

  localparam int H_VISIBLE_DEF  = 640;
  localparam int H_FRONT_DEF    = 16;
  localparam int H_SYNC_DEF     = 96;
  localparam int H_BACK_DEF     = 48;
  localparam int V_VISIBLE_DEF  = 480;
  localparam int V_FRONT_DEF    = 10;
  localparam int V_SYNC_DEF     = 2;
  localparam int V_BACK_DEF     = 33;
  localparam int SYNC_DELAY_DEF = 2;

  localparam int H_TOTAL_DEF = H_VISIBLE_DEF + H_FRONT_DEF + H_SYNC_DEF + H_BACK_DEF;
  localparam int V_TOTAL_DEF = V_VISIBLE_DEF + V_FRONT_DEF + V_SYNC_DEF + V_BACK_DEF;

  typedef logic [9:0] coord_t;

endpackage

// File: rtl/sync_delay_line.sv
// WIDTH x DEPTH register chain with synchronous reset to RST_VAL.
module sync_delay_line #(
  parameter int               WIDTH   = 1,
  parameter int               DEPTH   = 2,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [DEPTH-1:0][WIDTH-1:0] stage_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stage_q <= {DEPTH{RST_VAL}};
    end else begin
      stage_q[0] <= d_i;
      for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign q_o = stage_q[DEPTH-1];

endmodule

// File: rtl/vga_timing_controller.sv
// VGA raster counters and sync/blank decode. Define VGA_SYNC_DELAY_EN to delay
// hs/vs/blank by SYNC_DELAY cycles so they line up with the mappers' colour path.
module vga_timing_controller
  import vga_timing_pkg::*;
#(
  parameter int H_VISIBLE = H_VISIBLE_DEF,
  parameter int H_FRONT   = H_FRONT_DEF,
  parameter int H_SYNC    = H_SYNC_DEF,
  parameter int H_BACK    = H_BACK_DEF,
  parameter int V_VISIBLE = V_VISIBLE_DEF,
  parameter int V_FRONT   = V_FRONT_DEF,
  parameter int V_SYNC    = V_SYNC_DEF,
  parameter int V_BACK    = V_BACK_DEF
`ifdef VGA_SYNC_DELAY_EN
  ,
  parameter int SYNC_DELAY = SYNC_DELAY_DEF
`endif
) (
  input  logic        vga_clk,
  input  logic        reset,
  output logic [9:0]  DrawX,
  output logic [9:0]  DrawY,
  output logic        hs,
  output logic        vs,
  output logic        blank,
  output logic        frame_start,
  output logic        line_start,
  output logic [15:0] frame_count
);

  localparam int     H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int     V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam coord_t H_LAST  = coord_t'(H_TOTAL - 1);
  localparam coord_t V_LAST  = coord_t'(V_TOTAL - 1);
  localparam coord_t H_VIS   = coord_t'(H_VISIBLE);
  localparam coord_t V_VIS   = coord_t'(V_VISIBLE);
  localparam coord_t HS_BEG  = coord_t'(H_VISIBLE + H_FRONT);
  localparam coord_t HS_END  = coord_t'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam coord_t VS_BEG  = coord_t'(V_VISIBLE + V_FRONT);
  localparam coord_t VS_END  = coord_t'(V_VISIBLE + V_FRONT + V_SYNC);

  coord_t      hc_q, hc_d, vc_q, vc_d;
  logic [15:0] fc_q, fc_d;
  logic        hs_q, vs_q, blank_q, ls_q, fs_q;
  logic        hs_d, vs_d, blank_d, ls_d, fs_d;

  always_comb begin
    hc_d = hc_q + 1'b1;
    vc_d = vc_q;
    fc_d = fc_q;
    if (hc_q == H_LAST) begin
      hc_d = '0;
      if (vc_q == V_LAST) begin
        vc_d = '0;
        fc_d = fc_q + 16'd1;
      end else begin
        vc_d = vc_q + 1'b1;
      end
    end
  end

  // Flags decode the next coordinates so they register alongside them.
  always_comb begin
    hs_d    = !((hc_d >= HS_BEG) && (hc_d < HS_END));
    vs_d    = !((vc_d >= VS_BEG) && (vc_d < VS_END));
    blank_d = (hc_d < H_VIS) && (vc_d < V_VIS);
    ls_d    = (hc_d == '0);
    fs_d    = (hc_d == '0) && (vc_d == '0);
  end

  always_ff @(posedge vga_clk) begin
    if (reset) begin
      hc_q    <= '0;
      vc_q    <= '0;
      fc_q    <= '0;
      hs_q    <= 1'b1;
      vs_q    <= 1'b1;
      blank_q <= 1'b1;
      ls_q    <= 1'b1;
      fs_q    <= 1'b1;
    end else begin
      hc_q    <= hc_d;
      vc_q    <= vc_d;
      fc_q    <= fc_d;
      hs_q    <= hs_d;
      vs_q    <= vs_d;
      blank_q <= blank_d;
      ls_q    <= ls_d;
      fs_q    <= fs_d;
    end
  end

  assign DrawX       = hc_q;
  assign DrawY       = vc_q;
  assign frame_count = fc_q;
  assign line_start  = ls_q;
  assign frame_start = fs_q;

`ifdef VGA_SYNC_DELAY_EN
  logic [2:0] sync_dly;

  sync_delay_line #(
    .WIDTH   (3),
    .DEPTH   (SYNC_DELAY),
    .RST_VAL (3'b110)
  ) u_sync_dly (
    .clk_i (vga_clk),
    .rst_i (reset),
    .d_i   ({hs_q, vs_q, blank_q}),
    .q_o   (sync_dly)
  );

  assign {hs, vs, blank} = sync_dly;
`else
  assign hs    = hs_q;
  assign vs    = vs_q;
  assign blank = blank_q;
`endif

endmodule
